instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Fetch sequencer on the consumer side of the program-counter address bus. Enables the
//  PC onto the shared 16-bit tri-state address bus, samples the address, runs a read
//  handshake to instruction memory, and holds the fetched word for the decoder with a
//  valid/ready handshake. Pulses the PC count input after each instruction is consumed.
// PARAMETERS
//  ADDR_W      16  width of address bus and address registers
//  DATA_W      16  width of instruction word
//  SAMPLE_DLY  1   cycles between pcOutEn rising and addrBus sampling (1..7)
//  TIMEOUT     15  max REQ cycles without memAck before abort (2..255)
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  reset       in   1       synchronous, active-high; overrides every other input
//  start       in   1       level; 1 = keep fetching, 0 = stop at next instruction boundary
//  flush       in   1       abort current fetch, return to IDLE (branch/redirect)
//  addrBus     in   ADDR_W  shared tri-state address bus driven by PC when pcOutEn=1
//  pcOutEn     out  1       output enable to PC
//  pcCount     out  1       one-cycle advance pulse to PC
//  memAddr     out  ADDR_W  read address to instruction memory
//  memRd       out  1       read request, held until memAck or abort
//  memAck      in   1       memory response strobe; memData valid same cycle
//  memData     in   DATA_W  instruction word from memory
//  instr       out  DATA_W  fetched instruction to decoder
//  instrAddr   out  ADDR_W  address the held instruction was fetched from
//  instrValid  out  1       instr/instrAddr valid
//  instrReady  in   1       decoder accepts; transfer when instrValid & instrReady
//  memTimeout  out  1       sticky fault flag: a read timed out
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, every output 0, addr/instr regs 0, counters 0.
//  - States: IDLE, DRIVE, REQ, VALID, ADVANCE.
//  - IDLE: all strobes 0. start=1 -> DRIVE next cycle.
//  - DRIVE: pcOutEn=1 for SAMPLE_DLY+1 cycles; addrBus registered into addrReg on last
//    DRIVE cycle; then -> REQ with pcOutEn=0. Bus contents outside that cycle are ignored.
//  - REQ: memRd=1, memAddr=addrReg. Cycle counter cleared on entry, +1 per cycle without ack.
//    memAck=1 -> capture memData into instr, addrReg into instrAddr, memRd=0, -> VALID.
//    Counter reaches TIMEOUT-1 with no ack -> memRd=0, memTimeout=1, -> IDLE, no pcCount.
//    Ack on the timeout cycle: ack wins, no fault. memAck outside REQ ignored.
//  - VALID: instrValid=1, instr/instrAddr stable until transfer. Transfer -> ADVANCE.
//  - ADVANCE: instrValid=0, pcCount=1 for exactly one cycle; then start=1 -> DRIVE, else IDLE.
//  - Fetch-to-valid latency with immediate ack: start@T -> DRIVE T+1..T+1+SAMPLE_DLY,
//    REQ next, instrValid 1 cycle after ack cycle.
//  - start=0 mid-fetch: current fetch completes through ADVANCE, then IDLE.
//  - flush=1 in any non-IDLE state: next cycle IDLE, memRd/pcOutEn/instrValid=0, no pcCount.
//    Flush with transfer same cycle: flush wins, no pcCount. Flush in IDLE: no effect.
//  - memTimeout sticky; cleared only by reset.
//  - instrAddr is the PC address sampled; no arithmetic on it; wraps naturally at PC side.
// TESTING
//  1 reset, start=1, addrBus=16'h0000, memAck 1 cycle after memRd, instrReady=1 -> instr=memData,
//    instrAddr=0, one pcCount pulse; back-to-back repeat with addrBus=1,2,3 -> instrAddr=1,2,3.
//  2 instrReady=0 for 5 cycles in VALID, memData changes -> instr stable, pcCount stays 0 until ready.
//  3 memAck never asserted, TIMEOUT=15 -> memRd high 15 cycles, memTimeout=1, IDLE, pcCount 0.
//  4 flush during REQ, then late memAck -> ignored, instrValid 0, no pcCount; next start refetches.
//  5 addrBus=16'hFFFF then 16'h0000 -> instrAddr FFFF then 0000; reset mid-VALID -> all outputs 0 next cycle.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: PC address bus, instruction-memory read port and decoder handoff.
interface instr_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] addr_bus;
    logic              pc_out_en;
    logic              pc_count;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        input  addr_bus, mem_ack, mem_data, instr_ready,
        output pc_out_en, pc_count, mem_addr, mem_rd, instr, instr_addr, instr_valid
    );

    modport slave (
        output addr_bus, mem_ack, mem_data, instr_ready,
        input  pc_out_en, pc_count, mem_addr, mem_rd, instr, instr_addr, instr_valid
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch sequencer: samples the PC off the shared address bus, reads instruction memory,
// and hands the word to the decoder, pulsing the PC advance once it has been consumed.
//
// state   | meaning
// IDLE    | no fetch in progress, waiting for start
// DRIVE   | PC enabled onto addr_bus, sampled on the last cycle
// REQ     | memory read outstanding, timeout counter running
// VALID   | instruction held for the decoder
// ADVANCE | one-cycle PC advance pulse
module instr_fetch #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int SAMPLE_DLY = 1,
    parameter int TIMEOUT    = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic flush,
    output logic mem_timeout,
    instr_fetch_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        REQ     = 3'd2,
        VALID   = 3'd3,
        ADVANCE = 3'd4
    } state_t;

    // Both phases use one down-counter that terminates at zero.
    localparam logic [7:0] DRIVE_LOAD = 8'(SAMPLE_DLY);
    localparam logic [7:0] REQ_LOAD   = 8'(TIMEOUT - 1);

    state_t            state;
    state_t            next_state;
    logic [7:0]        cnt;
    logic [7:0]        cnt_next;
    logic              sample_addr;
    logic              capture;
    logic              timeout_hit;

    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] instr_addr_q;
    logic              pc_out_en_q;
    logic              pc_count_q;
    logic              mem_rd_q;
    logic              instr_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        next_state  = state;
        cnt_next    = (cnt == '0) ? cnt : cnt - 8'd1;
        sample_addr = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = DRIVE;
                    cnt_next   = DRIVE_LOAD;
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    sample_addr = 1'b1;
                    next_state  = REQ;
                    cnt_next    = REQ_LOAD;
                end
            end
            REQ: begin
                // An ack arriving on the last allowed cycle still completes the read.
                if (bus.mem_ack) begin
                    capture    = 1'b1;
                    next_state = VALID;
                end else if (cnt == '0) begin
                    timeout_hit = 1'b1;
                    next_state  = IDLE;
                end
            end
            VALID: begin
                if (bus.instr_ready) begin
                    next_state = ADVANCE;
                end
            end
            ADVANCE: begin
                if (start) begin
                    next_state = DRIVE;
                    cnt_next   = DRIVE_LOAD;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        // Redirect beats everything, including a same-cycle transfer or ack.
        if (flush && state != IDLE) begin
            next_state  = IDLE;
            sample_addr = 1'b0;
            capture     = 1'b0;
            timeout_hit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg      <= '0;
            instr_q       <= '0;
            instr_addr_q  <= '0;
            pc_out_en_q   <= 1'b0;
            pc_count_q    <= 1'b0;
            mem_rd_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            mem_timeout   <= 1'b0;
        end else begin
            if (sample_addr) begin
                addr_reg <= bus.addr_bus;
            end
            if (capture) begin
                instr_q      <= bus.mem_data;
                instr_addr_q <= addr_reg;
            end
            if (timeout_hit) begin
                mem_timeout <= 1'b1;
            end
            pc_out_en_q   <= (next_state == DRIVE);
            mem_rd_q      <= (next_state == REQ);
            instr_valid_q <= (next_state == VALID);
            pc_count_q    <= (next_state == ADVANCE);
        end
    end

    assign bus.pc_out_en   = pc_out_en_q;
    assign bus.pc_count    = pc_count_q;
    assign bus.mem_addr    = addr_reg;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.instr       = instr_q;
    assign bus.instr_addr  = instr_addr_q;
    assign bus.instr_valid = instr_valid_q;

endmodule
